// File: rtl/mem_pkg.sv
// Shared types for the RV32 load/store data memory: request parameters,
// response payload, controller states and the alignment helper.
package mem_pkg;

  typedef logic [31:0] arch_reg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2,
    MEM_SIZE_RSVD = 2'd3
  } mem_access_size_t;

  typedef enum logic {
    MEM_OP_LOAD  = 1'b0,
    MEM_OP_STORE = 1'b1
  } mem_op_t;

  typedef struct packed {
    mem_op_t          op;
    mem_access_size_t access_size;
    logic             read_unsigned;
  } mem_params_t;

  typedef struct packed {
    logic    err;
    arch_reg rdata;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mem_state_t;

  // Natural alignment check; only the two lane bits of the address matter.
  function automatic logic mem_misaligned(input logic [1:0] address,
                                          input mem_access_size_t access_size);
    case (access_size)
      MEM_SIZE_HALF: return address[0];
      MEM_SIZE_WORD: return address != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response pipeline: a DEPTH-stage valid + payload shift
// register. Responses leave in the order they entered.
module mem_rsp_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     in_valid,
  input  mem_rsp_t in_rsp,
  output logic     out_valid,
  output mem_rsp_t out_rsp,
  output logic     busy
);

  logic [DEPTH-1:0] valid_q;
  mem_rsp_t         rsp_q [DEPTH];

  // Shift every stage by one each cycle; idle slots carry zero payload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) rsp_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the previous
      // stage's old value, so the loop order below does not matter.
      valid_q[0] <= in_valid;
      rsp_q[0]   <= in_valid ? in_rsp : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        rsp_q[i]   <= rsp_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_rsp   = rsp_q[DEPTH-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/banked_data_mem.sv
// Byte-lane-banked data memory with a valid/ready request port, fixed
// read latency, error reporting and an init-mode preload port.
module banked_data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 16384,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        init_mode,
  input  logic        req_valid,
  output logic        req_ready,
  input  arch_reg     req_address,
  input  arch_reg     req_wdata,
  input  mem_params_t req_params,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        setup_write,
  input  logic [31:0] setup_address,
  input  logic [31:0] setup_data_in
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [7:0] bank [4][DEPTH_WORDS];

  mem_state_t  state;
  logic        busy;
  logic        accept;
  logic        is_store;
  logic        req_in_range;
  logic        setup_in_range;
  logic        req_err;
  logic [AW-1:0] req_index;
  logic [AW-1:0] setup_index;
  logic [AW-1:0] wr_index;
  logic [3:0]  req_lane_en;
  logic [3:0]  wr_en;
  logic [31:0] store_word;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  mem_rsp_t    pipe_in;
  mem_rsp_t    pipe_out;

  // Ready depends on registered state plus init_mode, so raising init_mode
  // blocks acceptance in that very cycle.
  assign req_ready = (state == RUN) && !init_mode;
  assign accept    = req_valid && req_ready;
  assign is_store  = (req_params.op == MEM_OP_STORE);

  assign req_index      = req_address[AW+1:2];
  assign setup_index    = setup_address[AW+1:2];
  assign req_in_range   = (req_address >> (AW + 2)) == '0;
  assign setup_in_range = (setup_address >> (AW + 2)) == '0;

  assign req_err = (req_params.access_size == MEM_SIZE_RSVD)
                || mem_misaligned(req_address[1:0], req_params.access_size)
                || !req_in_range;

  // Lane enables and lane-replicated store data for the request size.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no
    // latch is inferred.
    req_lane_en = '0;
    store_word  = '0;
    case (req_params.access_size)
      MEM_SIZE_BYTE: begin
        req_lane_en = 4'b0001 << req_address[1:0];
        store_word  = {4{req_wdata[7:0]}};
      end
      MEM_SIZE_HALF: begin
        req_lane_en = req_address[1] ? 4'b1100 : 4'b0011;
        store_word  = {2{req_wdata[15:0]}};
      end
      MEM_SIZE_WORD: begin
        req_lane_en = 4'b1111;
        store_word  = req_wdata;
      end
      default: ;
    endcase
  end

  // Single write port: preload owns it in INIT, accepted stores in RUN.
  always_comb begin
    wr_en    = '0;
    wr_index = req_index;
    wr_word  = store_word;
    if (state == INIT) begin
      wr_index = setup_index;
      wr_word  = setup_data_in;
      if (setup_write && setup_in_range) wr_en = 4'b1111;
    end else if (accept && is_store && !req_err) begin
      wr_en = req_lane_en;
    end
  end

  // Byte-lane storage writes.
  // NOTE: the arrays have no reset; contents survive reset_n by design and
  // a reset would prevent RAM inference.
  always_ff @(posedge clock) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_en[l]) bank[l][wr_index] <= wr_word[8*l +: 8];
    end
  end

  assign rd_word = {bank[3][req_index], bank[2][req_index],
                    bank[1][req_index], bank[0][req_index]};

  // Lane extraction and sign/zero extension of the load result.
  always_comb begin
    byte_sel  = rd_word[{req_address[1:0], 3'b000} +: 8];
    half_sel  = req_address[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (req_params.access_size)
      MEM_SIZE_BYTE: load_data = {{24{byte_sel[7] & ~req_params.read_unsigned}}, byte_sel};
      MEM_SIZE_HALF: load_data = {{16{half_sel[15] & ~req_params.read_unsigned}}, half_sel};
      MEM_SIZE_WORD: load_data = rd_word;
      default:       load_data = '0;
    endcase
  end

  assign pipe_in.err   = req_err;
  assign pipe_in.rdata = (req_err || is_store) ? '0 : load_data;

  mem_rsp_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rsp_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (accept),
    .in_rsp   (pipe_in),
    .out_valid(rsp_valid),
    .out_rsp  (pipe_out),
    .busy     (busy)
  );

  assign rsp_err   = pipe_out.err;
  assign rsp_rdata = pipe_out.rdata;

  // Mode controller: preload in INIT, serve in RUN, drain in-flight
  // responses before returning to INIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    if (!init_mode) state <= RUN;
        RUN:     if (init_mode) state <= busy ? DRAIN : INIT;
        DRAIN:   if (!busy) state <= INIT;
        default: state <= INIT;
      endcase
    end
  end

endmodule
